// File: rtl/fifo2usb_pkg.sv
// Shared types and constants for the FT232H synchronous-FIFO bridge.
// FSM state encoding and the RX almost-full margin live here.
package fifo2usb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_OE = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } usb_state_e;

    // Headroom kept free in the RX FIFO so in-flight bytes never overflow it.
    localparam int ALMOST_FULL_MARGIN = 4;

endpackage

// File: rtl/fifo2usb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    // Storage is not reset: emptiness is defined by the pointers and count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fifo2usb_sync.sv
// Bridge between local TX/RX FIFOs and an FT232H in 245 synchronous FIFO mode.
// Define SIWU_EN to pulse SIWU_N after a write burst that drains the TX FIFO.
module fifo2usb_sync
    import fifo2usb_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int WRFIFO_DEPTH  = 512,
    parameter int RDFIFO_DEPTH  = 512,
    parameter int SENDTHRESHOUD = 1,
    parameter int WUSEDW        = 9,
    parameter int RUSEDW        = 9
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              VALID,
    input  logic [WIDTH-1:0]  FIFO_DIN,
    output logic [WUSEDW-1:0] WR_USEDW,
    output logic              FULL,
    input  logic              LOAD,
    output logic              FIFO_VALID,
    output logic [WIDTH-1:0]  FIFO_DOUT,
    output logic              EMPTY,
    output logic [RUSEDW-1:0] RD_USEDW,
    inout  wire  [WIDTH-1:0]  D,
    input  logic              RXF_N,
    input  logic              TXE_N,
    output logic              RD_N,
    output logic              WR_N,
    output logic              SIWU_N,
    output logic              OE_N
);

    localparam int TX_CW = $clog2(WRFIFO_DEPTH + 1);
    localparam int RX_CW = $clog2(RDFIFO_DEPTH + 1);
    localparam logic [RX_CW-1:0] RX_AF_LEVEL = RX_CW'(RDFIFO_DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [TX_CW-1:0] TX_SEND_LEVEL = TX_CW'(SENDTHRESHOUD);

    // Handshakes: a TX word is accepted on an edge with VALID=1 and FULL=0; an RX
    // word is taken on an edge with LOAD=1 and EMPTY=0 and shows on FIFO_DOUT with
    // FIFO_VALID=1 in the following cycle. Toward the FT232H a byte moves on an edge
    // with RD_N=0 and RXF_N=0 (read) or WR_N=0 and TXE_N=0 (write).

    usb_state_e       r_state;
    usb_state_e       w_next_state;
    logic             w_oe_n;
    logic             w_rd_n;
    logic             w_wr_n;
    logic             w_d_en;

    logic [WIDTH-1:0] w_tx_head;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [TX_CW-1:0] w_tx_count;
    logic [WIDTH-1:0] w_rx_head;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [RX_CW-1:0] w_rx_count;
    logic             w_rx_afull;
    logic             w_rx_pop;
    logic             r_fifo_valid;
    logic [WIDTH-1:0] r_fifo_dout;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(WRFIFO_DEPTH)) u_tx_fifo (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_wr_en   (VALID),
        .i_wr_data (FIFO_DIN),
        .i_rd_en   (!w_wr_n),
        .o_rd_data (w_tx_head),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (w_tx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(RDFIFO_DEPTH)) u_rx_fifo (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_wr_en   (!w_rd_n),
        .i_wr_data (D),
        .i_rd_en   (LOAD),
        .o_rd_data (w_rx_head),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_count   (w_rx_count)
    );

    assign w_rx_afull = (w_rx_count >= RX_AF_LEVEL);
    assign w_rx_pop   = LOAD && !w_rx_empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes are decoded combinationally so they drop the same cycle the FT232H
    // deasserts RXF_N/TXE_N; the RD_N/WR_N low terms are exactly the FIFO push/pop.
    always_comb begin
        w_next_state = r_state;
        w_oe_n       = 1'b1;
        w_rd_n       = 1'b1;
        w_wr_n       = 1'b1;
        w_d_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RXF_N && !w_rx_afull) begin
                    w_next_state = ST_RD_OE;
                end else if (RXF_N && !TXE_N && (w_tx_count >= TX_SEND_LEVEL)) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_RD_OE: begin
                w_oe_n       = 1'b0;
                w_next_state = ST_READ;
            end
            ST_READ: begin
                w_oe_n = 1'b0;
                if (!RXF_N && !w_rx_afull) begin
                    w_rd_n = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_d_en = 1'b1;
                if (!w_tx_empty && !TXE_N) begin
                    w_wr_n = 1'b0;
                end
                if (w_tx_empty || TXE_N || !RXF_N) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_fifo_valid <= 1'b0;
            r_fifo_dout  <= '0;
        end else begin
            r_fifo_valid <= w_rx_pop;
            if (w_rx_pop) begin
                r_fifo_dout <= w_rx_head;
            end
        end
    end

`ifdef SIWU_EN
    logic r_siwu_n;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_siwu_n <= 1'b1;
        end else begin
            r_siwu_n <= !((r_state == ST_WRITE) && (w_next_state == ST_IDLE) && w_tx_empty);
        end
    end

    assign SIWU_N = r_siwu_n;
`else
    assign SIWU_N = 1'b1;
`endif

    assign D          = w_d_en ? w_tx_head : {WIDTH{1'bz}};
    assign OE_N       = w_oe_n;
    assign RD_N       = w_rd_n;
    assign WR_N       = w_wr_n;
    assign FULL       = w_tx_full;
    assign EMPTY      = w_rx_empty;
    assign WR_USEDW   = WUSEDW'(w_tx_count);
    assign RD_USEDW   = RUSEDW'(w_rx_count);
    assign FIFO_VALID = r_fifo_valid;
    assign FIFO_DOUT  = r_fifo_dout;

    // Full flag of the RX FIFO is never reached thanks to the almost-full margin.
    logic w_unused;
    assign w_unused = w_rx_full;

endmodule

// File: tb/tb_fifo2usb_sync.sv
// Directed bench for fifo2usb_sync with a small FT232H model and queue scoreboards.
module tb_fifo2usb_sync;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       VALID;
    logic [7:0] FIFO_DIN;
    logic [8:0] WR_USEDW;
    logic       FULL;
    logic       LOAD;
    logic       FIFO_VALID;
    logic [7:0] FIFO_DOUT;
    logic       EMPTY;
    logic [8:0] RD_USEDW;
    wire  [7:0] D;
    logic       RXF_N;
    logic       TXE_N;
    logic       RD_N;
    logic       WR_N;
    logic       SIWU_N;
    logic       OE_N;

    logic [7:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] src_q[$];
    logic [7:0] ft_d;
    logic       ft_en;
    logic       ft_take;

    int checks;
    int errors;
    int cyc;
    int wr_strobes;
    int rd_strobes;
    int oe_low_cnt;
    int wr_run;
    int wr_run_max;
    int first_rd_cyc;
    int first_wr_cyc;
    int last_rd_cyc;
    int oe_lead;
    logic prev_rd_n;
    logic prev_wr_n;
    int wr_base;
    int rd_base;
    int oe_base;

    fifo2usb_sync dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .VALID      (VALID),
        .FIFO_DIN   (FIFO_DIN),
        .WR_USEDW   (WR_USEDW),
        .FULL       (FULL),
        .LOAD       (LOAD),
        .FIFO_VALID (FIFO_VALID),
        .FIFO_DOUT  (FIFO_DOUT),
        .EMPTY      (EMPTY),
        .RD_USEDW   (RD_USEDW),
        .D          (D),
        .RXF_N      (RXF_N),
        .TXE_N      (TXE_N),
        .RD_N       (RD_N),
        .WR_N       (WR_N),
        .SIWU_N     (SIWU_N),
        .OE_N       (OE_N)
    );

    // FT232H drives the bus only while the bridge holds OE_N low.
    assign D = (!OE_N) ? ft_d : 8'hzz;

    // Clock and cycle counter
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge sys_clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FT232H model: presents the head of src_q, advances on each accepted read strobe.
    initial begin
        RXF_N   = 1'b1;
        ft_d    = 8'h00;
        ft_take = 1'b0;
        forever begin
            @(negedge sys_clk);
            ft_take = (RD_N === 1'b0) && (RXF_N === 1'b0);
            @(posedge sys_clk);
            #2;
            if (ft_take && src_q.size() > 0) void'(src_q.pop_front());
            RXF_N = !(ft_en && src_q.size() > 0);
            ft_d  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Monitor: write/read scoreboards and bus-protocol observations.
    initial begin
        wr_strobes   = 0;
        rd_strobes   = 0;
        oe_low_cnt   = 0;
        wr_run       = 0;
        wr_run_max   = 0;
        first_rd_cyc = -1;
        first_wr_cyc = -1;
        last_rd_cyc  = -1;
        oe_lead      = 0;
        prev_rd_n    = 1'b1;
        prev_wr_n    = 1'b1;
        forever begin
            @(negedge sys_clk);
            check("bus_exclusive", {31'd0, !(WR_N == 1'b0 && (RD_N == 1'b0 || OE_N == 1'b0))}, 32'd1);
            if (!OE_N) oe_low_cnt = oe_low_cnt + 1;
            if (!WR_N && !TXE_N) begin
                wr_strobes = wr_strobes + 1;
                wr_run     = wr_run + 1;
                if (wr_run > wr_run_max) wr_run_max = wr_run;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (prev_wr_n && last_rd_cyc >= 0)
                    check("turnaround", {31'd0, (cyc - last_rd_cyc) >= 2}, 32'd1);
                if (exp_wr_q.size() == 0) begin
                    check("wr_unexpected", {24'd0, D}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_data", {24'd0, D}, {24'd0, exp_wr_q.pop_front()});
                end
            end else begin
                wr_run = 0;
            end
            if (OE_N) begin
                oe_lead = 0;
            end else if (RD_N) begin
                oe_lead = oe_lead + 1;
            end else if (prev_rd_n) begin
                check("oe_lead", oe_lead, 32'd1);
            end
            if (!RD_N) begin
                rd_strobes  = rd_strobes + 1;
                last_rd_cyc = cyc;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (FIFO_VALID) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_unexpected", {24'd0, FIFO_DOUT}, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", {24'd0, FIFO_DOUT}, {24'd0, exp_rd_q.pop_front()});
                end
            end
            prev_rd_n = RD_N;
            prev_wr_n = WR_N;
        end
    end

    // Driver tasks: all start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d, input logic expect_accept);
        VALID    = 1'b1;
        FIFO_DIN = d;
        if (expect_accept) exp_wr_q.push_back(d);
        tick();
        VALID = 1'b0;
    endtask

    task automatic send_from_ft(input logic [7:0] d);
        src_q.push_back(d);
        exp_rd_q.push_back(d);
    endtask

    task automatic load_rx(input int n);
        LOAD = 1'b1;
        repeat (n) tick();
        LOAD = 1'b0;
    endtask

    task automatic mark();
        wr_base = wr_strobes;
        rd_base = rd_strobes;
        oe_base = oe_low_cnt;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sys_rst_n = 1'b0;
        VALID     = 1'b0;
        LOAD      = 1'b0;
        FIFO_DIN  = 8'h00;
        TXE_N     = 1'b0;
        ft_en     = 1'b0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_wr_n", {31'd0, WR_N}, 32'd1);
        check("rst_rd_n", {31'd0, RD_N}, 32'd1);
        check("rst_oe_n", {31'd0, OE_N}, 32'd1);
        check("rst_siwu_n", {31'd0, SIWU_N}, 32'd1);
        check("rst_fifo_valid", {31'd0, FIFO_VALID}, 32'd0);
        check("rst_fifo_dout", {24'd0, FIFO_DOUT}, 32'd0);
        check("rst_empty", {31'd0, EMPTY}, 32'd1);
        check("rst_full", {31'd0, FULL}, 32'd0);
        check("rst_wr_usedw", {23'd0, WR_USEDW}, 32'd0);
        check("rst_rd_usedw", {23'd0, RD_USEDW}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick();

        // Two-word write burst
        mark();
        push_tx(8'hEB, 1'b1);
        push_tx(8'hBB, 1'b1);
        repeat (8) tick();
        check("basic_wr_count", wr_strobes - wr_base, 32'd2);
        check("basic_wr_usedw", {23'd0, WR_USEDW}, 32'd0);
        check("basic_no_rd", rd_strobes - rd_base, 32'd0);
        check("basic_no_oe", oe_low_cnt - oe_base, 32'd0);

        // Held off by TXE_N, then released as one burst
        TXE_N = 1'b1;
        mark();
        push_tx(8'hA1, 1'b1);
        push_tx(8'hA2, 1'b1);
        push_tx(8'hA3, 1'b1);
        push_tx(8'hA4, 1'b1);
        repeat (3) tick();
        check("hold_wr_usedw", {23'd0, WR_USEDW}, 32'd4);
        check("hold_no_wr", wr_strobes - wr_base, 32'd0);
        wr_run_max = 0;
        TXE_N = 1'b0;
        repeat (10) tick();
        check("hold_wr_count", wr_strobes - wr_base, 32'd4);
        check("hold_wr_run", wr_run_max, 32'd4);
        check("hold_wr_usedw_end", {23'd0, WR_USEDW}, 32'd0);

        // Three-byte read burst then unload
        mark();
        send_from_ft(8'h11);
        send_from_ft(8'h22);
        send_from_ft(8'h33);
        ft_en = 1'b1;
        repeat (10) tick();
        ft_en = 1'b0;
        check("rd_count", rd_strobes - rd_base, 32'd3);
        check("rd_usedw", {23'd0, RD_USEDW}, 32'd3);
        check("rd_not_empty", {31'd0, EMPTY}, 32'd0);
        load_rx(3);
        repeat (2) tick();
        check("rd_empty_after", {31'd0, EMPTY}, 32'd1);
        check("rd_usedw_after", {23'd0, RD_USEDW}, 32'd0);
        check("rd_q_drained", exp_rd_q.size(), 32'd0);

        // Read and write pending together: read first, then turnaround, then write
        TXE_N = 1'b1;
        push_tx(8'hC1, 1'b1);
        push_tx(8'hC2, 1'b1);
        send_from_ft(8'h44);
        send_from_ft(8'h55);
        mark();
        first_rd_cyc = -1;
        first_wr_cyc = -1;
        ft_en = 1'b1;
        TXE_N = 1'b0;
        repeat (15) tick();
        ft_en = 1'b0;
        check("prio_order", {31'd0, (first_rd_cyc >= 0) && (first_wr_cyc > first_rd_cyc)}, 32'd1);
        check("prio_rd_count", rd_strobes - rd_base, 32'd2);
        check("prio_wr_count", wr_strobes - wr_base, 32'd2);
        load_rx(2);
        repeat (2) tick();
        check("prio_q_drained", exp_rd_q.size() + exp_wr_q.size(), 32'd0);

        // Fill TX to depth, overflow attempt, load on empty RX
        TXE_N = 1'b1;
        for (int i = 0; i < 512; i++) push_tx(8'(i), 1'b1);
        check("fill_full", {31'd0, FULL}, 32'd1);
        check("fill_usedw", {23'd0, WR_USEDW}, 32'd0);
        push_tx(8'hFF, 1'b0);
        check("ovf_full", {31'd0, FULL}, 32'd1);
        check("ovf_usedw", {23'd0, WR_USEDW}, 32'd0);
        load_rx(1);
        check("empty_load_valid", {31'd0, FIFO_VALID}, 32'd0);
        check("empty_load_hold", {24'd0, FIFO_DOUT}, 32'h55);

        // Reset in the middle of a write burst
        mark();
        TXE_N = 1'b0;
        repeat (6) tick();
        check("mid_wr_count", wr_strobes - wr_base, 32'd5);
        check("mid_wr_active", {31'd0, WR_N}, 32'd0);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("abort_wr_n", {31'd0, WR_N}, 32'd1);
        check("abort_wr_usedw", {23'd0, WR_USEDW}, 32'd0);
        check("abort_full", {31'd0, FULL}, 32'd0);
        check("abort_oe_n", {31'd0, OE_N}, 32'd1);
        exp_wr_q.delete();
        tick();
        check("abort_fifo_dout", {24'd0, FIFO_DOUT}, 32'd0);
        check("abort_siwu_n", {31'd0, SIWU_N}, 32'd1);
        sys_rst_n = 1'b1;
        mark();
        repeat (5) tick();
        check("post_rst_no_wr", wr_strobes - wr_base, 32'd0);
        check("post_rst_empty", {31'd0, EMPTY}, 32'd1);
        check("end_queues", exp_wr_q.size() + exp_rd_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo2usb_sync.md
FIFO2USB_SYNC -- requirements
Module: fifo2usb_sync

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, data width; WRFIFO_DEPTH, 512, TX FIFO depth; RDFIFO_DEPTH, 512, RX FIFO depth; SENDTHRESHOUD, 1, minimum TX words before a USB write burst; WUSEDW, 9, TX count width; RUSEDW, 9, RX count width.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low; sys_clk is the FT232H 60 MHz CLKOUT domain.
REQ-003 Ports (name direction width meaning) SHALL be:
- sys_clk in 1 clock
- sys_rst_n in 1 async active-low reset
- VALID in 1 TX write strobe
- FIFO_DIN in WIDTH TX data
- WR_USEDW out WUSEDW TX fill count
- FULL out 1 TX FIFO full
- LOAD in 1 RX pop request
- FIFO_VALID out 1 FIFO_DOUT valid
- FIFO_DOUT out WIDTH RX data
- EMPTY out 1 RX FIFO empty
- RD_USEDW out RUSEDW RX fill count
- D inout WIDTH FT232H data bus
- RXF_N in 1 FT232H has data
- TXE_N in 1 FT232H can accept data
- RD_N out 1 read strobe
- WR_N out 1 write strobe
- SIWU_N out 1 send-immediate
- OE_N out 1 bus output enable to FT232H

Function
REQ-004 VALID=1 with FULL=0 SHALL push FIFO_DIN into TX FIFO at that edge; VALID while FULL SHALL drop the word and leave contents unchanged.
REQ-005 LOAD=1 with EMPTY=0 SHALL pop RX FIFO; FIFO_VALID SHALL be 1 the next cycle with popped word on FIFO_DOUT, else 0; LOAD while EMPTY ignored; FIFO_DOUT holds last value.
REQ-006 FIFO counts SHALL reflect same-edge push and pop (net unchanged when both occur); FULL at count=DEPTH, EMPTY at count=0; pointers wrap modulo depth.
REQ-007 USB FSM SHALL have states IDLE, RD_OE, READ, WRITE.
REQ-008 IDLE->RD_OE when RXF_N=0 and RD_USEDW < RDFIFO_DEPTH-4; read has priority over write.
REQ-009 IDLE->WRITE when RXF_N=1, TXE_N=0, WR_USEDW >= SENDTHRESHOUD.
REQ-010 RD_OE: OE_N=0, RD_N=1, one cycle, then ->READ.
REQ-011 READ: OE_N=0; RD_N=0 while RXF_N=0 and RX not almost-full (count >= RDFIFO_DEPTH-4); each edge with RD_N=0 and RXF_N=0 SHALL push D into RX FIFO; on RXF_N=1 or almost-full ->IDLE.
REQ-012 WRITE: D driven with TX FIFO head (first-word-fall-through); WR_N=0 (combinational) while TX nonempty and TXE_N=0; each edge with WR_N=0 and TXE_N=0 SHALL pop TX FIFO; ->IDLE when TX empty, TXE_N=1, or RXF_N=0.
REQ-013 D SHALL be driven only in WRITE and high-Z otherwise; OE_N SHALL be 0 only in RD_OE/READ; every READ/WRITE exit passes through IDLE for at least one cycle (bus turnaround).
REQ-014 WR_N and RD_N SHALL never be 0 simultaneously.

Reset
REQ-015 Reset SHALL set state IDLE, RD_N=WR_N=OE_N=SIWU_N=1, D high-Z, FIFO_VALID=0, FIFO_DOUT=0, both FIFOs empty (EMPTY=1, FULL=0, counts 0); reset mid-burst aborts immediately and discards FIFO contents.

Configuration
REQ-016 With SIWU_EN defined, SIWU_N SHALL pulse 0 for one cycle on the first IDLE cycle after a WRITE burst that emptied the TX FIFO; without SIWU_EN, SIWU_N SHALL be constant 1.

Structure
REQ-017 Package fifo2usb_pkg SHALL hold the FSM state enum and the almost-full margin constant (4).
REQ-018 One sub-module sync_fifo (parameterised width/depth, FWFT, count output) SHALL be instantiated for TX and RX.

Verification
REQ-019 After reset, TXE_N=0, RXF_N=1, SENDTHRESHOUD=1, VALID with 8'hEB then 8'hBB -> WR_N=0 on two edges, D=EB then BB, WR_USEDW returns to 0, RD_N and OE_N stay 1.
REQ-020 TXE_N=1 during 4 pushes -> WR_N stays 1, WR_USEDW=4; TXE_N to 0 -> four consecutive writes in push order.
REQ-021 RXF_N=0 with D sequence 11,22,33 for three cycles, then 1 -> OE_N low one cycle before RD_N, RD_USEDW=3; LOAD pulses -> FIFO_DOUT 11,22,33 with FIFO_VALID.
REQ-022 RXF_N=0 and TX nonempty simultaneously -> read serviced first; write starts after one IDLE turnaround once RXF_N=1.
REQ-023 Fill TX to WRFIFO_DEPTH with TXE_N=1, extra VALID -> FULL=1, count unchanged; LOAD on empty RX -> FIFO_VALID=0.
REQ-024 Reset asserted mid-WRITE -> WR_N=1, D high-Z, WR_USEDW=0 immediately.
